// File: rtl/mips_pkg.sv
// Shared MIPS pipeline package: XALU opcode encodings used by control and by
// the multiply/divide unit. The MADD family encodings (9-12) are only acted
// on when the unit is built with XALU_MADD_EN.
package mips_pkg;

    localparam int XALU_OP_W = 4;

    localparam logic [XALU_OP_W-1:0] XALU_NONE  = 4'd0;
    localparam logic [XALU_OP_W-1:0] XALU_MULT  = 4'd1;
    localparam logic [XALU_OP_W-1:0] XALU_MULTU = 4'd2;
    localparam logic [XALU_OP_W-1:0] XALU_DIV   = 4'd3;
    localparam logic [XALU_OP_W-1:0] XALU_DIVU  = 4'd4;
    localparam logic [XALU_OP_W-1:0] XALU_MFHI  = 4'd5;
    localparam logic [XALU_OP_W-1:0] XALU_MFLO  = 4'd6;
    localparam logic [XALU_OP_W-1:0] XALU_MTHI  = 4'd7;
    localparam logic [XALU_OP_W-1:0] XALU_MTLO  = 4'd8;
    localparam logic [XALU_OP_W-1:0] XALU_MADD  = 4'd9;
    localparam logic [XALU_OP_W-1:0] XALU_MADDU = 4'd10;
    localparam logic [XALU_OP_W-1:0] XALU_MSUB  = 4'd11;
    localparam logic [XALU_OP_W-1:0] XALU_MSUBU = 4'd12;

endpackage

// File: rtl/xalu_div.sv
// Combinational 32-bit divider for the XALU. Divides magnitudes, then fixes
// the signs: quotient truncates toward zero, remainder takes the sign of the
// dividend. valid is low for a zero divisor so the caller can skip the commit.
module xalu_div (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        valid
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    // Magnitude divide followed by sign fix-up.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        uq    = '0;
        ur    = '0;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        valid = (b != 32'd0);
        if (valid) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
        // 0x80000000 / -1: magnitude quotient 0x80000000 negates to itself.
        quo = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem = neg_a ? (~ur + 32'd1) : ur;
    end

endmodule

// File: rtl/xalu_muldiv.sv
// XALU multiply/divide unit with the HI/LO register pair. The result is
// computed in the start cycle and held pending; it is committed to HI/LO when
// the down-counter expires, modelling a fixed MULT/DIV latency.
// Optional feature: define XALU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module xalu_muldiv
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XALU_OP_W-1:0] op,
    input  logic [31:0]          a,
    input  logic [31:0]          b,
    input  logic                 start,
    output logic                 busy,
    output logic [31:0]          out,
    output logic [31:0]          hi,
    output logic [31:0]          lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

    if (MULT_CYCLES < 1 || MULT_CYCLES > 16 || DIV_CYCLES < 1 || DIV_CYCLES > 16) begin : g_bad_cycles
        $error("xalu_muldiv: MULT_CYCLES and DIV_CYCLES must be in 1..16");
    end

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi_p;
    logic [31:0] lo_p;
    logic        p_valid;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic        div_valid;

    logic        is_md;
    logic [63:0] md_res;
    logic        md_valid;
    logic [3:0]  md_cnt;

    // Low 64 bits of the extended operands give the exact 32x32 products.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    xalu_div u_div (
        .a         (a),
        .b         (b),
        .is_signed (op == XALU_DIV),
        .quo       (div_quo),
        .rem       (div_rem),
        .valid     (div_valid)
    );

    // Decode the opcode into the pending result, its validity and latency.
    always_comb begin
        is_md    = 1'b0;
        md_res   = '0;
        md_valid = 1'b0;
        md_cnt   = MULT_CNT;
        case (op)
            XALU_MULT:  begin is_md = 1'b1; md_res = prod_s; md_valid = 1'b1; end
            XALU_MULTU: begin is_md = 1'b1; md_res = prod_u; md_valid = 1'b1; end
            XALU_DIV, XALU_DIVU: begin
                is_md    = 1'b1;
                md_res   = {div_rem, div_quo};
                md_valid = div_valid;
                md_cnt   = DIV_CNT;
            end
`ifdef XALU_MADD_EN
            XALU_MADD:  begin is_md = 1'b1; md_res = {hi, lo} + prod_s; md_valid = 1'b1; end
            XALU_MADDU: begin is_md = 1'b1; md_res = {hi, lo} + prod_u; md_valid = 1'b1; end
            XALU_MSUB:  begin is_md = 1'b1; md_res = {hi, lo} - prod_s; md_valid = 1'b1; end
            XALU_MSUBU: begin is_md = 1'b1; md_res = {hi, lo} - prod_u; md_valid = 1'b1; end
`endif
            default: ;
        endcase
    end

    // State machine, latency counter, pending and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the pending registers are reset along with HI/LO so an
            // interrupted operation can never leak a stale result later.
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            hi_p    <= '0;
            lo_p    <= '0;
            p_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (start && is_md) begin
                        hi_p    <= md_res[63:32];
                        lo_p    <= md_res[31:0];
                        p_valid <= md_valid;
                        cnt     <= md_cnt;
                        state   <= BUSY;
                    end else if (op == XALU_MTHI) begin
                        hi <= a;
                    end else if (op == XALU_MTLO) begin
                        lo <= a;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (p_valid) begin
                            hi <= hi_p;
                            lo <= lo_p;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

    // XALUOut_E: move-from reads are combinational from HI/LO.
    always_comb begin
        case (op)
            XALU_MFHI: out = hi;
            XALU_MFLO: out = lo;
            default:   out = '0;
        endcase
    end

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: directed cases for each operation and
// the boundaries, plus randomized operations checked against an arithmetic
// reference model of HI/LO.
module tb_xalu_muldiv;
    import mips_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .a     (a),
        .b     (b),
        .start (start),
        .busy  (busy),
        .out   (out),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol: start must never arrive while the unit is busy.
    always @(posedge clk) begin
        if (!reset && start && busy) $error("protocol: start while busy");
    end

    // Reference model: new {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_md(input logic [3:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] cur);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = longint'(x);
        longint unsigned uy = longint'(y);
        longint          q;
        longint          r;
        case (o)
            XALU_MULT:  return 64'(sx * sy);
            XALU_MULTU: return 64'(ux * uy);
            XALU_DIV: begin
                if (y == 0) return cur;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            XALU_DIVU: begin
                if (y == 0) return cur;
                return {32'(ux % uy), 32'(ux / uy)};
            end
`ifdef XALU_MADD_EN
            XALU_MADD:  return cur + 64'(sx * sy);
            XALU_MADDU: return cur + 64'(ux * uy);
            XALU_MSUB:  return cur - 64'(sx * sy);
            XALU_MSUBU: return cur - 64'(ux * uy);
`endif
            default:    return cur;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        return (o == XALU_DIV || o == XALU_DIVU) ? DC : MC;
    endfunction

    // Issue one start and count the cycles busy is seen high (bounded).
    task automatic issue_md(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int busy_cyc, output bit early);
        logic [63:0] old;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        old = {hi, lo};
        @(negedge clk);
        start = 1'b0; op = XALU_NONE; a = '0; b = '0;
        busy_cyc = 0;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busy_cyc++;
            if ({hi, lo} !== old) early = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = XALU_NONE; a = '0; b = '0; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || out !== 32'd0) begin
            failures++;
            $display("FAIL reset busy=%b hi=%h lo=%h out=%h expected 0/0/0/0", busy, hi, lo, out);
        end
    endtask

    task automatic test_mult();
        int cyc; bit early;
        issue_md(XALU_MULT, 32'hFFFF_FFFE, 32'd3, cyc, early);
        checks++;
        if (cyc != MC || early) begin
            failures++;
            $display("FAIL mult_busy cycles=%0d early=%0d expected %0d/0", cyc, early, MC);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_result hi=%h lo=%h expected ffffffff/fffffffa", hi, lo);
        end
        op = XALU_MFHI; #1;
        checks++;
        if (out !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mfhi out=%h expected ffffffff", out);
        end
        op = XALU_MFLO; #1;
        checks++;
        if (out !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mflo out=%h expected fffffffa", out);
        end
        op = XALU_NONE;
    endtask

    task automatic test_multu();
        int cyc; bit early;
        issue_md(XALU_MULTU, 32'hFFFF_FFFF, 32'd2, cyc, early);
        checks++;
        if (cyc != MC || early || hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu cycles=%0d early=%0d hi=%h lo=%h expected %0d/0/00000001/fffffffe",
                     cyc, early, hi, lo, MC);
        end
    endtask

    task automatic test_div();
        int cyc; bit early;
        issue_md(XALU_DIV, 32'hFFFF_FFF9, 32'd2, cyc, early);
        checks++;
        if (cyc != DC || early || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div cycles=%0d early=%0d hi=%h lo=%h expected %0d/0/ffffffff/fffffffd",
                     cyc, early, hi, lo, DC);
        end
        issue_md(XALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, early);
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_overflow hi=%h lo=%h expected 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_divu_zero();
        int cyc; bit early;
        issue_md(XALU_DIVU, 32'd10, 32'd3, cyc, early);
        checks++;
        if (cyc != DC || hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL divu cycles=%0d hi=%h lo=%h expected %0d/00000001/00000003", cyc, hi, lo, DC);
        end
        issue_md(XALU_DIV, 32'd77, 32'd0, cyc, early);
        checks++;
        if (cyc != DC || hi !== 32'd1 || lo !== 32'd3) begin
            failures++;
            $display("FAIL div_by_zero cycles=%0d hi=%h lo=%h expected %0d/00000001/00000003", cyc, hi, lo, DC);
        end
    endtask

    task automatic test_mt();
        logic [31:0] old_hi;
        old_hi = hi;
        @(negedge clk);
        op = XALU_MTLO; a = 32'h0000_1234;
        @(negedge clk);
        op = XALU_NONE; a = '0;
        checks++;
        if (lo !== 32'h0000_1234 || hi !== old_hi || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo lo=%h hi=%h busy=%b expected 00001234/%h/0", lo, hi, busy, old_hi);
        end
        op = XALU_MTHI; a = 32'hCAFE_0001;
        @(negedge clk);
        op = XALU_MFHI; a = '0; #1;
        checks++;
        if (out !== 32'hCAFE_0001 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_mfhi out=%h busy=%b expected cafe0001/0", out, busy);
        end
        op = XALU_NONE;
    endtask

    task automatic test_ignored_start();
        logic [63:0] old;
        old = {hi, lo};
        @(negedge clk);
        op = XALU_MFLO; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = XALU_NONE;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== old) begin
            failures++;
            $display("FAIL start_non_md busy=%b hilo=%h expected 0/%h", busy, {hi, lo}, old);
        end
`ifndef XALU_MADD_EN
        @(negedge clk);
        op = XALU_MADD; a = 32'd3; b = 32'd4; start = 1'b1; #1;
        checks++;
        if (out !== 32'd0) begin
            failures++;
            $display("FAIL reserved_out out=%h expected 00000000", out);
        end
        @(negedge clk);
        start = 1'b0; op = XALU_NONE;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== old) begin
            failures++;
            $display("FAIL reserved_start busy=%b hilo=%h expected 0/%h", busy, {hi, lo}, old);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = XALU_MULT; a = 32'd1234567; b = 32'd7654321; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = XALU_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        repeat (MC + 3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL no_late_commit busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_random();
        logic [63:0] m;
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          cyc;
        bit          early;
        do_reset();
        m = '0;
        for (int n = 0; n < 40; n++) begin
`ifdef XALU_MADD_EN
            o = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(9, 12));
`else
            o = 4'($urandom_range(1, 4));
`endif
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                op = XALU_MTHI; a = $urandom;
                m[63:32] = a;
                @(negedge clk);
                op = XALU_NONE;
            end
            issue_md(o, x, y, cyc, early);
            m = ref_md(o, x, y, m);
            checks++;
            if (cyc != latency(o) || early || {hi, lo} !== m) begin
                failures++;
                $display("FAIL rand op=%0d a=%h b=%h cycles=%0d early=%0d hilo=%h expected %0d/0/%h",
                         o, x, y, cyc, early, {hi, lo}, latency(o), m);
            end
            op = XALU_MFLO; #1;
            checks++;
            if (out !== m[31:0]) begin
                failures++;
                $display("FAIL rand_mflo out=%h expected %h", out, m[31:0]);
            end
            op = XALU_NONE;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu_zero();
        test_mt();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
